// File: rtl/avr_ctrl_seq.sv
// avr_ctrl_seq: control sequencer between fetch and the register file/ALU.
// Decodes the fetched word, steers fetch through pc_src/jmp, and runs the
// second-word and data-memory phases of JMP/LDS/STS.
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   instr, sreg      fetched word and status flags {I,T,H,S,V,N,Z,C}
//   mem_ack/rdata    data memory completion and read data
//   pc_src, jmp      fetch control and relative offset / absolute target
//   alu_en, reg_we   ALU result valid, register write strobe
//   wb_sel_mem       write-back source (1 = mem_rdata)
//   rd_addr, d_addr  destination register, data memory address
//   mem_req, mem_we  data memory request and direction (1 = store)
//   busy, bus_err    multi-cycle sequencing active, access timeout pulse
module avr_ctrl_seq #(
    parameter int ACK_TIMEOUT  = 15,
    parameter int RESET_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] instr,
    input  logic [7:0]  sreg,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [2:0]  pc_src,
    output logic [15:0] jmp,
    output logic        alu_en,
    output logic        reg_we,
    output logic        wb_sel_mem,
    output logic [4:0]  rd_addr,
    output logic [15:0] d_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic        busy,
    output logic        bus_err
);

    localparam int CW = 8;

    localparam logic [2:0] PC_RST  = 3'b000;
    localparam logic [2:0] PC_HOLD = 3'b001;
    localparam logic [2:0] PC_INC  = 3'b010;
    localparam logic [2:0] PC_REL  = 3'b100;
    localparam logic [2:0] PC_ABS  = 3'b101;

    typedef enum logic [1:0] {
        S_RESET_HOLD,
        S_EXEC,
        S_OP2,
        S_MEM_WAIT
    } state_t;

    typedef enum logic [1:0] {
        C_JMP,
        C_LDS,
        C_STS
    } cls_t;

    state_t         state_q, state_d;
    cls_t           cls_q, cls_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4:0]     rd_q, rd_d;
    logic [15:0]    d_addr_q, d_addr_d;

    logic           is_addc, is_sub, is_logic, is_imm, is_alu;
    logic           is_rjmp, is_br, is_jmp, is_lds, is_sts;
    logic           br_taken;
    logic [15:0]    rel12, rel7;
    logic [4:0]     rd_exec;

    // mem_rdata is consumed by the register file; only the strobes live here
    logic           unused_rdata;
    assign unused_rdata = ^mem_rdata;

    assign is_addc  = (instr[15:13] == 3'b000) && (instr[11:10] == 2'b11);
    assign is_sub   = (instr[15:10] == 6'b000110);
    assign is_logic = (instr[15:12] == 4'b0010);
    assign is_imm   = (instr[15:12] == 4'b0101) || (instr[15:12] == 4'b1110);
    assign is_alu   = is_addc | is_sub | is_logic | is_imm;
    assign is_rjmp  = (instr[15:12] == 4'b1100);
    assign is_br    = (instr[15:11] == 5'b11110);
    assign is_jmp   = (instr[15:9] == 7'b1001010) && (instr[3:1] == 3'b110);
    assign is_lds   = (instr[15:9] == 7'b1001000) && (instr[3:0] == 4'b0000);
    assign is_sts   = (instr[15:9] == 7'b1001001) && (instr[3:0] == 4'b0000);

    // BRBS (b=0) takes on a set flag, BRBC (b=1) on a clear one
    assign br_taken = (sreg[instr[2:0]] == ~instr[10]);
    assign rel12    = {{4{instr[11]}}, instr[11:0]} + 16'd1;
    assign rel7     = {{9{instr[9]}}, instr[9:3]} + 16'd1;
    // immediate forms only address r16..r31
    assign rd_exec  = is_imm ? {1'b1, instr[7:4]} : instr[8:4];

    assign d_addr = d_addr_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_RESET_HOLD;
            cls_q    <= C_JMP;
            cnt_q    <= '0;
            rd_q     <= '0;
            d_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            d_addr_q <= d_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        d_addr_d   = d_addr_q;
        pc_src     = PC_RST;
        jmp        = '0;
        alu_en     = 1'b0;
        reg_we     = 1'b0;
        wb_sel_mem = 1'b0;
        rd_addr    = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        bus_err    = 1'b0;

        unique case (state_q)
            S_RESET_HOLD: begin
                if (cnt_q == CW'(RESET_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_EXEC: begin
                pc_src  = PC_INC;
                rd_addr = rd_exec;
                unique case (1'b1)
                    is_alu: begin
                        alu_en = 1'b1;
                        reg_we = 1'b1;
                    end
                    is_rjmp: begin
                        pc_src = PC_REL;
                        jmp    = rel12;
                    end
                    is_br: begin
                        if (br_taken) begin
                            pc_src = PC_REL;
                            jmp    = rel7;
                        end
                    end
                    is_jmp, is_lds, is_sts: begin
                        rd_d    = instr[8:4];
                        state_d = S_OP2;
                        cls_d   = is_jmp ? C_JMP : (is_lds ? C_LDS : C_STS);
                    end
                    default: ;
                endcase
            end

            S_OP2: begin
                busy    = 1'b1;
                rd_addr = rd_q;
                if (cls_q == C_JMP) begin
                    pc_src  = PC_ABS;
                    jmp     = instr;
                    state_d = S_EXEC;
                end else begin
                    pc_src   = PC_INC;
                    d_addr_d = instr;
                    cnt_d    = '0;
                    state_d  = S_MEM_WAIT;
                end
            end

            S_MEM_WAIT: begin
                busy    = 1'b1;
                pc_src  = PC_HOLD;
                rd_addr = rd_q;
                mem_req = 1'b1;
                mem_we  = (cls_q == C_STS);
                // an ack on the final counted cycle still wins over timeout
                if (mem_ack) begin
                    reg_we     = (cls_q == C_LDS);
                    wb_sel_mem = (cls_q == C_LDS);
                    state_d    = S_EXEC;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    bus_err = 1'b1;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = S_RESET_HOLD;
        endcase

        // a reset cycle never commits a write or reports an error
        if (RST) begin
            alu_en     = 1'b0;
            reg_we     = 1'b0;
            wb_sel_mem = 1'b0;
            bus_err    = 1'b0;
        end
    end

endmodule
